// File: rtl/rf_write_arbiter.sv
// Register-file write-port sequencer and arbiter.
// After reset it sweeps zero into every register, then shares the single write port between
// the load unit (req0) and the ALU (req1) with valid/ready handshakes. The write is registered,
// so an accepted request reaches the register file one cycle later.
// Optional feature: define RF_ARB_RR_EN to replace fixed req0>req1 priority with round-robin.
module rf_write_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned STALL_W = 16,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [AW-1:0]      req0_rd,
  input  logic [XLEN-1:0]    req0_data,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [AW-1:0]      req1_rd,
  input  logic [XLEN-1:0]    req1_data,
  output logic               req1_ready,
  output logic               rf_reg_write,
  output logic [AW-1:0]      rf_rd,
  output logic [XLEN-1:0]    rf_write_data,
  output logic               busy,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  localparam logic [AW-1:0]      IdxOne   = AW'(1);
  localparam logic [AW-1:0]      IdxLast  = AW'(NREGS - 1);
  localparam logic [STALL_W-1:0] StallOne = STALL_W'(1);
  localparam logic [STALL_W-1:0] StallMax = '1;

  state_e              state_q, state_d;
  logic [AW-1:0]       clr_idx_q, clr_idx_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic                we_q, we_d;
  logic [AW-1:0]       rd_q, rd_d;
  logic [XLEN-1:0]     data_q, data_d;
  logic                grant0, grant1;
  logic                xfer0, xfer1;
  logic                stalled;

`ifdef RF_ARB_RR_EN
  // Index of the requester granted on the most recent transfer.
  logic last_grant_q, last_grant_d;
`endif

  // Grant selection from the current valids; nothing is granted during the sweep.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StRun) begin
`ifdef RF_ARB_RR_EN
      if (req0_valid && req1_valid) begin
        // On conflict favour whoever did not win last time.
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
`else
      grant0 = req0_valid;
      grant1 = req1_valid & ~req0_valid;
`endif
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xfer0      = req0_valid & req0_ready;
  assign xfer1      = req1_valid & req1_ready;
  assign stalled    = (req0_valid & ~req0_ready) | (req1_valid & ~req1_ready);

  // Next-state: sweep sequencing, write-port register and stall counter.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    stall_d   = stall_q;
    we_d      = 1'b0;
    rd_d      = rd_q;
    data_d    = data_q;
`ifdef RF_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      StClear: begin
        we_d      = 1'b1;
        rd_d      = clr_idx_q;
        data_d    = '0;
        clr_idx_d = clr_idx_q + IdxOne;
        if (clr_idx_q == IdxLast) begin
          clr_idx_d = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (xfer0) begin
          // Writes to x0 are consumed but never reach the register file.
          we_d   = (req0_rd != '0);
          rd_d   = req0_rd;
          data_d = req0_data;
        end else if (xfer1) begin
          we_d   = (req1_rd != '0);
          rd_d   = req1_rd;
          data_d = req1_data;
        end
`ifdef RF_ARB_RR_EN
        if (xfer0) begin
          last_grant_d = 1'b0;
        end else if (xfer1) begin
          last_grant_d = 1'b1;
        end
`endif
        if (stalled && (stall_q != StallMax)) begin
          stall_d = stall_q + StallOne;
        end
      end
      default: state_d = StClear;
    endcase
  end

  // State registers; reset also discards any request accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClear;
      clr_idx_q <= '0;
      stall_q   <= '0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
`ifdef RF_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      stall_q   <= stall_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
`ifdef RF_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign rf_reg_write  = we_q;
  assign rf_rd         = rd_q;
  assign rf_write_data = data_q;
  assign busy          = (state_q == StClear);
  assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (default parameters).
// Inputs change 2 time units after a rising edge; registered outputs are sampled there too,
// combinational readys 1 unit after the inputs change.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_rd, req1_rd;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_reg_write;
  logic [4:0]  rf_rd;
  logic [31:0] rf_write_data;
  logic        busy;
  logic [15:0] stall_cnt;

  int nvec = 0;
  int nerr = 0;

  rf_write_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req0_rd       (req0_rd),
    .req0_data     (req0_data),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_rd       (req1_rd),
    .req1_data     (req1_data),
    .req1_ready    (req1_ready),
    .rf_reg_write  (rf_reg_write),
    .rf_rd         (rf_rd),
    .rf_write_data (rf_write_data),
    .busy          (busy),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Expected write order for two back-to-back conflict pairs (req0: rd 3,5; req1: rd 4,6).
  int exp_order [4];
  int exp_stall_pairs;

  initial begin
`ifdef RF_ARB_RR_EN
    exp_order       = '{3, 4, 5, 6};
    exp_stall_pairs = 4;
`else
    exp_order       = '{3, 5, 4, 6};
    exp_stall_pairs = 3;
`endif
    rst        = 1'b1;
    req0_valid = 1'b1;
    req0_rd    = 5'd9;
    req0_data  = 32'h99;
    req1_valid = 1'b1;
    req1_rd    = 5'd10;
    req1_data  = 32'hAA;
    repeat (3) tick();

    // Reset state (valids held high: readys must still be low).
    check_eq("rst_we", rf_reg_write, 0);
    check_eq("rst_rd", rf_rd, 0);
    check_eq("rst_data", rf_write_data, 0);
    check_eq("rst_busy", busy, 1);
    check_eq("rst_rdy0", req0_ready, 0);
    check_eq("rst_rdy1", req1_ready, 0);
    check_eq("rst_stall", stall_cnt, 0);

    // Clear sweep: 32 writes of zero, rd 0..31; busy drops once rd=31 is on the port.
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick();
      check_eq("sweep_we", rf_reg_write, 1);
      check_eq("sweep_rd", rf_rd, 64'(i));
      check_eq("sweep_data", rf_write_data, 0);
      if (i < 31) begin
        check_eq("sweep_busy", busy, 1);
        check_eq("sweep_rdy0", req0_ready, 0);
        check_eq("sweep_rdy1", req1_ready, 0);
      end else begin
        check_eq("sweep_done_busy", busy, 0);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    check_eq("idle_we", rf_reg_write, 0);
    check_eq("idle_rd_hold", rf_rd, 31);
    check_eq("sweep_stall", stall_cnt, 0);

    // Single requester: req1 alone.
    req1_valid = 1'b1;
    req1_rd    = 5'd5;
    req1_data  = 32'hDEADBEEF;
    #1;
    check_eq("r1_rdy1", req1_ready, 1);
    check_eq("r1_rdy0", req0_ready, 0);
    tick();
    req1_valid = 1'b0;
    check_eq("r1_we", rf_reg_write, 1);
    check_eq("r1_rd", rf_rd, 5);
    check_eq("r1_data", rf_write_data, 32'hDEADBEEF);

    // Conflict: req0 wins first, req1 follows; one stall cycle.
    req0_valid = 1'b1;
    req0_rd    = 5'd3;
    req0_data  = 32'h11;
    req1_valid = 1'b1;
    req1_rd    = 5'd4;
    req1_data  = 32'h22;
    #1;
    check_eq("cf_rdy0", req0_ready, 1);
    check_eq("cf_rdy1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    check_eq("cf1_we", rf_reg_write, 1);
    check_eq("cf1_rd", rf_rd, 3);
    check_eq("cf1_data", rf_write_data, 32'h11);
    #1;
    check_eq("cf2_rdy1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    check_eq("cf2_rd", rf_rd, 4);
    check_eq("cf2_data", rf_write_data, 32'h22);
    check_eq("cf_stall", stall_cnt, 1);

    // Two conflict pairs: order depends on the arbitration policy.
    req0_valid = 1'b1;
    req0_rd    = 5'd3;
    req0_data  = 32'h33;
    req1_valid = 1'b1;
    req1_rd    = 5'd4;
    req1_data  = 32'h44;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("pair_we", rf_reg_write, 1);
      check_eq("pair_rd", rf_rd, 64'(exp_order[k]));
      check_eq("pair_data", rf_write_data, 64'(exp_order[k] * 32'h11));
      if (exp_order[k] % 2 == 1) begin
        if (exp_order[k] == 3) begin
          req0_rd   = 5'd5;
          req0_data = 32'h55;
        end else begin
          req0_valid = 1'b0;
        end
      end else begin
        if (exp_order[k] == 4) begin
          req1_rd   = 5'd6;
          req1_data = 32'h66;
        end else begin
          req1_valid = 1'b0;
        end
      end
    end
    check_eq("pair_stall", stall_cnt, 64'(exp_stall_pairs));

    // Write to x0: consumed, but no write enable; address/data still update.
    req0_valid = 1'b1;
    req0_rd    = 5'd0;
    req0_data  = 32'h55;
    #1;
    check_eq("x0_rdy0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    check_eq("x0_we", rf_reg_write, 0);
    check_eq("x0_rd", rf_rd, 0);
    check_eq("x0_data", rf_write_data, 32'h55);
    tick();
    check_eq("hold_we", rf_reg_write, 0);
    check_eq("hold_data", rf_write_data, 32'h55);

    // Reset in RUN, then again mid-sweep at index 17: sweep restarts from 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (17) tick();
    check_eq("mid_rd16", rf_rd, 16);
    rst = 1'b1;
    tick();
    check_eq("mid_rst_we", rf_reg_write, 0);
    check_eq("mid_rst_rd", rf_rd, 0);
    check_eq("mid_rst_busy", busy, 1);
    check_eq("mid_rst_stall", stall_cnt, 0);
    rst = 1'b0;
    tick();
    check_eq("restart_we", rf_reg_write, 1);
    check_eq("restart_rd", rf_rd, 0);
    repeat (31) tick();
    check_eq("restart_end_rd", rf_rd, 31);
    check_eq("restart_busy", busy, 0);

`ifndef RF_ARB_RR_EN
    // Saturation: req0 always wins, req1 stalls for 2^16+5 cycles.
    req0_valid = 1'b1;
    req0_rd    = 5'd7;
    req0_data  = 32'h77;
    req1_valid = 1'b1;
    req1_rd    = 5'd8;
    req1_data  = 32'h88;
    repeat (65534) tick();
    check_eq("sat_pre", stall_cnt, 16'hFFFE);
    repeat (7) tick();
    check_eq("sat_max", stall_cnt, 16'hFFFF);
    check_eq("sat_rd", rf_rd, 7);
    check_eq("sat_rdy1", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
